// File: rtl/imem_loader_if.sv
// Descriptor handshake between an instruction-descriptor source and the imem loader.
// The source drives valid, last and the symbolic fields; the loader returns ready.
interface imem_loader_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_last;
   logic [3:0]  in_kind;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [4:0]  in_shamt;
   logic [5:0]  in_funct;
   logic [15:0] in_imm;
   logic [25:0] in_target;

   modport master (
      output in_valid, in_last, in_kind, in_rs, in_rt, in_rd,
             in_shamt, in_funct, in_imm, in_target,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_last, in_kind, in_rs, in_rt, in_rd,
             in_shamt, in_funct, in_imm, in_target,
      output in_ready
   );
endinterface

// File: rtl/imem_loader.sv
// Encodes symbolic instruction descriptors into MIPS words and writes them
// sequentially into instruction memory through a registered write port.
module imem_loader #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   imem_loader_if.slave  di,
   output logic          we,
   output logic [AW-1:0] waddr,
   output logic [31:0]   wdata,
   output logic [AW:0]   count,
   output logic          full,
   output logic          done,
   output logic          err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_FULL = 2'd2
   } state_t;

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          full_q, full_d;
   logic          err_q, err_d;
   logic          we_q, we_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          done_q, done_d;

   logic          in_ready;
   logic          accept;
   logic          legal;
   logic [AW:0]   count_inc;
   logic [31:0]   enc_word;

   // Opcode values match what the main control decoder expects per class.
   function automatic logic [5:0] kind_opcode(input logic [3:0] kind);
      logic [5:0] op;
      case (kind)
         4'd0:    op = 6'b000000;
         4'd1:    op = 6'b100011;
         4'd2:    op = 6'b101011;
         4'd3:    op = 6'b000100;
         4'd4:    op = 6'b000101;
         4'd5:    op = 6'b001010;
         4'd6:    op = 6'b001000;
         4'd7:    op = 6'b000010;
         default: op = 6'b000000;
      endcase
      return op;
   endfunction

   function automatic logic [31:0] encode(
      input logic [3:0]  kind,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [4:0]  shamt,
      input logic [5:0]  funct,
      input logic [15:0] imm,
      input logic [25:0] target
   );
      logic [5:0]  op;
      logic [31:0] word;
      op = kind_opcode(kind);
      case (kind)
         4'd0:    word = {op, rs, rt, rd, shamt, funct};
         4'd7:    word = {op, target};
         default: word = {op, rs, rt, imm};
      endcase
      return word;
   endfunction

   // start takes priority over a descriptor presented in the same cycle.
   assign in_ready    = (state_q == S_LOAD) && !start;
   assign di.in_ready = in_ready;
   assign accept      = di.in_valid && in_ready;
   assign legal       = !di.in_kind[3];
   assign count_inc   = count_q + (AW+1)'(1);
   assign enc_word    = encode(di.in_kind, di.in_rs, di.in_rt, di.in_rd,
                               di.in_shamt, di.in_funct, di.in_imm, di.in_target);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      full_d  = full_q;
      err_d   = err_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      done_d  = 1'b0;

      if (start) begin
         state_d = S_LOAD;
         ptr_d   = '0;
         count_d = '0;
         full_d  = 1'b0;
         err_d   = 1'b0;
      end else if (accept) begin
         if (legal) begin
            we_d    = 1'b1;
            waddr_d = ptr_q;
            wdata_d = enc_word;
            ptr_d   = ptr_q + AW'(1);
            count_d = count_inc;
            full_d  = (count_inc == DEPTH_C);
         end else begin
            err_d = 1'b1;
         end
         // A closing descriptor returns to IDLE even when it also fills memory.
         if (di.in_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end else if (legal && (count_inc == DEPTH_C)) begin
            state_d = S_FULL;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         full_q  <= full_d;
         err_q   <= err_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
      end
   end

   assign we    = we_q;
   assign waddr = waddr_q;
   assign wdata = wdata_q;
   assign count = count_q;
   assign full  = full_q;
   assign done  = done_q;
   assign err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as descriptors
// are driven and compared whenever the loader strobes a write.
module tb_imem_loader;
   localparam int DEPTH = 4;
   localparam int AW    = 3;

   logic          clk;
   logic          reset;
   logic          start;
   logic          we;
   logic [AW-1:0] waddr;
   logic [31:0]   wdata;
   logic [AW:0]   count;
   logic          full;
   logic          done;
   logic          err;

   imem_loader_if bus ();

   imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .di    (bus.slave),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .count (count),
      .full  (full),
      .done  (done),
      .err   (err)
   );

   int          checks   = 0;
   int          failures = 0;
   int          tb_ptr   = 0;
   logic [63:0] sb[$];
   logic [63:0] mon_e;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (we === 1'b1) begin
         if (sb.size() == 0) begin
            chk("spurious_we", 32'(we), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("waddr", 32'(waddr), mon_e[63:32]);
            chk("wdata", wdata, mon_e[31:0]);
         end
      end
   end

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      tb_ptr = 0;
   endtask

   // Caller sits just after a rising edge; returns just after the next one.
   task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                       input logic [15:0] imm, input logic [25:0] tg, input logic last,
                       input logic exp_acc, input logic [31:0] exp_w);
      bus.in_valid  = 1'b1;
      bus.in_kind   = k;
      bus.in_rs     = rs;
      bus.in_rt     = rt;
      bus.in_rd     = rd;
      bus.in_shamt  = sh;
      bus.in_funct  = fn;
      bus.in_imm    = imm;
      bus.in_target = tg;
      bus.in_last   = last;
      #1;
      chk("in_ready", 32'(bus.in_ready), 32'(exp_acc));
      if (exp_acc && !k[3]) begin
         sb.push_back({32'(tb_ptr), exp_w});
         tb_ptr++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      idle();
      bus.in_kind = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
      bus.in_shamt = '0; bus.in_funct = '0; bus.in_imm = '0; bus.in_target = '0;
      #12;
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ready", 32'(bus.in_ready), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Reset mid-session with valid held: pending ADDI write must vanish.
      pulse_start();
      send(4'd6, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0, 1'b1, 32'h20080005);
      #1;
      reset = 1'b1;
      sb.delete();
      tb_ptr = 0;
      #1;
      chk("mrst_we", 32'(we), 32'd0);
      chk("mrst_waddr", 32'(waddr), 32'd0);
      chk("mrst_wdata", wdata, 32'd0);
      chk("mrst_count", 32'(count), 32'd0);
      chk("mrst_flags", {29'd0, full, done, err}, 32'd0);
      chk("mrst_ready", 32'(bus.in_ready), 32'd0);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst_ready", 32'(bus.in_ready), 32'd0);
      chk("post_rst_count", 32'(count), 32'd0);
      idle();

      // Single ADDI.
      pulse_start();
      send(4'd6, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0, 1'b1, 32'h20080005);
      idle();
      chk("addi_we", 32'(we), 32'd1);
      chk("addi_count", 32'(count), 32'd1);
      @(posedge clk); #1;
      chk("addi_we_low", 32'(we), 32'd0);
      chk("addi_wdata_hold", wdata, 32'h20080005);

      // Back-to-back R / BEQ / J closing the session.
      pulse_start();
      send(4'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0, 1'b1, 32'h01095020);
      send(4'd3, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0, 1'b1, 32'h1109FFFF);
      send(4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010, 1'b1, 1'b1, 32'h08000010);
      idle();
      chk("j_done", 32'(done), 32'd1);
      chk("j_count", 32'(count), 32'd3);
      chk("j_idle_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      chk("j_done_once", 32'(done), 32'd0);

      // Fill DEPTH words with continuous LW; fifth descriptor is refused.
      pulse_start();
      for (int i = 0; i < DEPTH; i++)
         send(4'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0, 1'b1, 32'h8FA80004);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'(DEPTH));
      send(4'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0, 1'b0, 32'h8FA80004);
      idle();
      chk("fill_no_we", 32'(we), 32'd0);
      chk("fill_count_hold", 32'(count), 32'(DEPTH));

      // Illegal kind between two SW words.
      pulse_start();
      chk("restart_full", 32'(full), 32'd0);
      send(4'd2, 5'd29, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0008, 26'd0, 1'b0, 1'b1, 32'hAFA90008);
      send(4'd9, 5'd29, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0, 1'b1, 32'h0);
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_no_we", 32'(we), 32'd0);
      chk("ill_count", 32'(count), 32'd1);
      send(4'd2, 5'd29, 5'd9, 5'd0, 5'd0, 6'd0, 16'h000C, 26'd0, 1'b0, 1'b1, 32'hAFA9000C);
      chk("ill_count2", 32'(count), 32'd2);

      // start together with valid: start wins, pending SW still lands.
      start = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_kind  = 4'd5;
      #1;
      chk("start_blocks_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      start  = 1'b0;
      tb_ptr = 0;
      chk("start_count", 32'(count), 32'd0);
      chk("start_err", 32'(err), 32'd0);
      send(4'd5, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3F, 16'h7FFF, 26'd0, 1'b0, 1'b1, 32'h28227FFF);
      send(4'd4, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b1, 1'b1, 32'h14640010);
      idle();
      chk("bne_done", 32'(done), 32'd1);

      // Illegal descriptor with last closes the session.
      pulse_start();
      send(4'd15, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1, 1'b1, 32'h0);
      idle();
      chk("ill_last_done", 32'(done), 32'd1);
      chk("ill_last_err", 32'(err), 32'd1);
      chk("ill_last_ready", 32'(bus.in_ready), 32'd0);

      // Filling descriptor also marked last: IDLE with full set.
      pulse_start();
      for (int i = 0; i < DEPTH; i++)
         send(4'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, (i == DEPTH-1), 1'b1, 32'h8FA80004);
      idle();
      chk("fl_done", 32'(done), 32'd1);
      chk("fl_full", 32'(full), 32'd1);
      @(posedge clk); #1;
      chk("fl_idle_ready", 32'(bus.in_ready), 32'd0);
      chk("fl_full_hold", 32'(full), 32'd1);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "bench timeout");
   end
endmodule
